// File: rtl/sr_cmd_gen.sv
// Command front-end for the SR latch: synchronizes and debounces set/reset requests and
// issues fixed-width, non-overlapping S/R pulses. Optional macro SR_CMD_SET_PRIO_EN: set wins conflicts.
module sr_cmd_gen #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_W    = 2,
  parameter int unsigned GAP        = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic rst_req,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic conflict,
  output logic q_model
);

  localparam int unsigned DW     = $clog2(DEB_CYCLES + 1);
  localparam int unsigned CMAX   = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int unsigned CW     = $clog2(CMAX + 1);
  localparam int unsigned GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {IDLE, SET_P, RST_P, HOLD} state_t;

  // Channel bit 0 is set, bit 1 is reset
  logic [1:0]    w_req;
  logic [1:0]    r_sync1, r_sync2, r_deb, r_deb_d, r_pend;
  logic [DW-1:0] r_dcnt [2];
  logic [1:0]    w_rise, w_pend_clr;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_s, r_r, r_busy, r_conf, r_q;
  logic          w_s_nxt, w_r_nxt, w_busy_nxt, w_conf_nxt, w_q_nxt;

  assign w_req  = {rst_req, set_req};
  assign w_rise = r_deb & ~r_deb_d;

  // Synchronizer, debouncer and one-deep pending flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_pend  <= '0;
      for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1 <= w_req;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_pend  <= (r_pend & ~w_pend_clr) | w_rise;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          r_deb[i]  <= ~r_deb[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_busy  <= 1'b0;
      r_conf  <= 1'b0;
      r_q     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_busy  <= w_busy_nxt;
      r_conf  <= w_conf_nxt;
      r_q     <= w_q_nxt;
    end
  end

  // Next-state and next-output logic; outputs change on state entry
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;
    w_r_nxt     = r_r;
    w_busy_nxt  = r_busy;
    w_conf_nxt  = 1'b0;
    w_q_nxt     = r_q;
    w_pend_clr  = 2'b00;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_pend == 2'b11) begin
          w_conf_nxt = 1'b1;
          w_pend_clr = 2'b11;
          w_busy_nxt = 1'b1;
`ifdef SR_CMD_SET_PRIO_EN
          w_state_nxt = SET_P;
          w_s_nxt     = 1'b1;
          w_q_nxt     = 1'b1;
`else
          w_state_nxt = RST_P;
          w_r_nxt     = 1'b1;
          w_q_nxt     = 1'b0;
`endif
        end else if (r_pend[0]) begin
          w_pend_clr  = 2'b01;
          w_state_nxt = SET_P;
          w_s_nxt     = 1'b1;
          w_q_nxt     = 1'b1;
          w_busy_nxt  = 1'b1;
        end else if (r_pend[1]) begin
          w_pend_clr  = 2'b10;
          w_state_nxt = RST_P;
          w_r_nxt     = 1'b1;
          w_q_nxt     = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      SET_P, RST_P: begin
        if (r_cnt == CW'(PULSE_W - 1)) begin
          w_s_nxt   = 1'b0;
          w_r_nxt   = 1'b0;
          w_cnt_nxt = '0;
          if (GAP == 0) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = HOLD;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (r_cnt == CW'(GAP_M1)) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign s_out    = r_s;
  assign r_out    = r_r;
  assign busy     = r_busy;
  assign conflict = r_conf;
  assign q_model  = r_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Scoreboard bench for sr_cmd_gen: expected pulses are queued at stimulus time and matched
// against the observed S/R pulses of two instances (default params, and PULSE_W=1/GAP=0).
module tb_sr_cmd_gen;

  localparam int DEB = 4;

  typedef struct {
    int d;
    bit is_set;
    int cyc;
    bit q;
    bit conf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] set_i, rst_i, s_o, r_o, busy_o, conf_o, q_o;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sr_cmd_gen #(.DEB_CYCLES(DEB), .PULSE_W(2), .GAP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .set_req(set_i[0]), .rst_req(rst_i[0]),
    .s_out(s_o[0]), .r_out(r_o[0]), .busy(busy_o[0]), .conflict(conf_o[0]), .q_model(q_o[0])
  );

  sr_cmd_gen #(.DEB_CYCLES(DEB), .PULSE_W(1), .GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .set_req(set_i[1]), .rst_req(rst_i[1]),
    .s_out(s_o[1]), .r_out(r_o[1]), .busy(busy_o[1]), .conflict(conf_o[1]), .q_model(q_o[1])
  );

  function automatic int pw(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int gp(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int d, input bit is_set, input int c, input bit conf);
    exp_t e;
    e.d = d; e.is_set = is_set; e.cyc = c; e.q = is_set; e.conf = conf;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse monitor: matches rising edges against the scoreboard and checks invariants
  logic [1:0] ps = '0, pr = '0, pb = '0;
  int         pstart[2], lastfall[2], bstart[2];
  bit         hadfall[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin : mon
      int   idx;
      exp_t e;
      bit   rise, fall;
      if (!rst_n) begin
        ps[d] = 1'b0; pr[d] = 1'b0; pb[d] = 1'b0; hadfall[d] = 1'b0;
      end else begin
        check($sformatf("overlap%0d", d), int'(s_o[d] & r_o[d]), 0);
        rise = (s_o[d] & ~ps[d]) | (r_o[d] & ~pr[d]);
        fall = (ps[d] & ~s_o[d]) | (pr[d] & ~r_o[d]);
        if (rise) begin
          idx = -1;
          foreach (sb[i]) if (idx < 0 && sb[i].d == d) idx = i;
          if (idx < 0) begin
            check($sformatf("unexpected_pulse%0d", d), 1, 0);
          end else begin
            e = sb[idx];
            sb.delete(idx);
            check($sformatf("kind%0d", d), int'(s_o[d]), int'(e.is_set));
            check($sformatf("start%0d", d), cyc, e.cyc);
            check($sformatf("q_model%0d", d), int'(q_o[d]), int'(e.q));
            check($sformatf("conflict%0d", d), int'(conf_o[d]), int'(e.conf));
            check($sformatf("busy_at_start%0d", d), int'(busy_o[d]), 1);
            if (hadfall[d])
              check($sformatf("gap%0d", d), int'(cyc - lastfall[d] >= gp(d) + 1), 1);
          end
          pstart[d] = cyc;
        end else begin
          check($sformatf("conflict_idle%0d", d), int'(conf_o[d]), 0);
        end
        if (fall) begin
          check($sformatf("width%0d", d), cyc - pstart[d], pw(d));
          lastfall[d] = cyc;
          hadfall[d]  = 1'b1;
        end
        if (busy_o[d] & ~pb[d]) bstart[d] = cyc;
        if (~busy_o[d] & pb[d])
          check($sformatf("busy_len%0d", d), cyc - bstart[d], pw(d) + gp(d));
        ps[d] = s_o[d];
        pr[d] = r_o[d];
        pb[d] = busy_o[d];
      end
    end
  end

  initial begin
    int e;
    rst_n = 1'b0;
    set_i = '0;
    rst_i = '0;
    wait_cyc(3);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_s%0d", d), int'(s_o[d]), 0);
      check($sformatf("rst_r%0d", d), int'(r_o[d]), 0);
      check($sformatf("rst_busy%0d", d), int'(busy_o[d]), 0);
      check($sformatf("rst_conf%0d", d), int'(conf_o[d]), 0);
      check($sformatf("rst_q%0d", d), int'(q_o[d]), 1);
    end
    rst_n = 1'b1;
    wait_cyc(3);

    // Plain set request
    set_i[0] = 1'b1;
    push(0, 1'b1, cyc + DEB + 4, 1'b0);
    wait_cyc(12);
    set_i[0] = 1'b0;
    wait_cyc(15);

    // Glitch shorter than the debounce window
    set_i[0] = 1'b1;
    wait_cyc(3);
    set_i[0] = 1'b0;
    wait_cyc(20);
    check("glitch_q", int'(q_o[0]), 1);
    check("glitch_busy", int'(busy_o[0]), 0);

    // Simultaneous requests
    set_i[0] = 1'b1;
    rst_i[0] = 1'b1;
`ifdef SR_CMD_SET_PRIO_EN
    push(0, 1'b1, cyc + DEB + 4, 1'b1);
`else
    push(0, 1'b0, cyc + DEB + 4, 1'b1);
`endif
    wait_cyc(12);
    set_i[0] = 1'b0;
    rst_i[0] = 1'b0;
    wait_cyc(15);

    // Reset request arriving while the set pulse is active
    e = cyc;
    set_i[0] = 1'b1;
    push(0, 1'b1, e + DEB + 4, 1'b0);
    wait_cyc(1);
    rst_i[0] = 1'b1;
    push(0, 1'b0, e + DEB + 4 + 2 + 1 + 1, 1'b0);
    wait_cyc(20);
    set_i[0] = 1'b0;
    rst_i[0] = 1'b0;
    wait_cyc(15);
    check("after_rst_pulse_q", int'(q_o[0]), 0);

    // Asynchronous reset in the middle of a set pulse
    e = cyc;
    set_i[0] = 1'b1;
    push(0, 1'b1, e + DEB + 4, 1'b0);
    wait_cyc(DEB + 4);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_s", int'(s_o[0]), 0);
    check("abort_q", int'(q_o[0]), 1);
    check("abort_busy", int'(busy_o[0]), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    push(0, 1'b1, cyc + DEB + 4, 1'b0);
    wait_cyc(15);
    set_i[0] = 1'b0;
    wait_cyc(15);

    // Single-cycle pulses with no gap
    e = cyc;
    set_i[1] = 1'b1;
    push(1, 1'b1, e + DEB + 4, 1'b0);
    wait_cyc(1);
    rst_i[1] = 1'b1;
    push(1, 1'b0, e + DEB + 4 + 1 + 0 + 1, 1'b0);
    wait_cyc(15);
    set_i[1] = 1'b0;
    rst_i[1] = 1'b0;
    wait_cyc(15);
    set_i[1] = 1'b1;
    push(1, 1'b1, cyc + DEB + 4, 1'b0);
    wait_cyc(12);
    set_i[1] = 1'b0;
    wait_cyc(15);
    rst_i[1] = 1'b1;
    push(1, 1'b0, cyc + DEB + 4, 1'b0);
    wait_cyc(12);
    rst_i[1] = 1'b0;
    wait_cyc(15);
    set_i[1] = 1'b1;
    rst_i[1] = 1'b1;
`ifdef SR_CMD_SET_PRIO_EN
    push(1, 1'b1, cyc + DEB + 4, 1'b1);
`else
    push(1, 1'b0, cyc + DEB + 4, 1'b1);
`endif
    wait_cyc(12);
    set_i[1] = 1'b0;
    rst_i[1] = 1'b0;
    wait_cyc(15);

    check("scoreboard_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Command front-end for the SR latch stage: takes two raw, asynchronous request lines (set, reset), synchronizes and debounces them, and issues clean, fixed-width, never-overlapping S and R pulses to the downstream SR flip-flop. Simultaneous requests are arbitrated so S and R are never high together. A shadow copy of the expected latch state is maintained for status and checking.

## Interface
Parameters:
- DEB_CYCLES, 4: consecutive stable cycles needed to accept a level change; legal range ≥1.
- PULSE_W, 2: width of each S/R pulse in cycles; legal range ≥1.
- GAP, 1: mandatory low cycles after every pulse; legal range ≥0.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- set_req  input  1  raw set request; asynchronous and may bounce.
- rst_req  input  1  raw reset request; asynchronous and may bounce.
- s_out  output  1  set pulse to the latch.
- r_out  output  1  reset pulse to the latch.
- busy  output  1  high while the state machine is outside IDLE.
- conflict  output  1  one-cycle strobe when both requests win arbitration together.
- q_model  output  1  expected latch state.

## Operation
- Each request passes through a 2-flop synchronizer, then a debouncer.
- Debouncer: a counter runs while the synchronized value differs from the debounced level and clears when they match. After DEB_CYCLES consecutive differing cycles, the debounced level toggles.
- A rising edge of a debounced level sets that channel's pending flag.
  - One pending flag per channel, one deep; repeated edges merge.
  - Falling edges are ignored.
- FSM states: IDLE, SET_P, RST_P, HOLD.
  - IDLE, only set pending: go to SET_P, clear set pending.
  - IDLE, only reset pending: go to RST_P, clear reset pending.
  - IDLE, both pending: assert conflict for 1 cycle, clear both flags, go to RST_P (reset dominates, matching the latch's 1/1 → 0 rule).
  - SET_P or RST_P: drive s_out or r_out for exactly PULSE_W cycles, then go to HOLD. If GAP=0, go directly to IDLE.
  - HOLD: GAP cycles with both outputs low, then go to IDLE.
- Requests arriving outside IDLE are latched as pending and served after returning to IDLE.
- q_model: set to 1 on entry to SET_P; cleared to 0 on entry to RST_P.
- s_out, r_out, busy, conflict and q_model are all registered outputs.
- Invariants:
  - s_out and r_out are never both 1.
  - Every pulse is exactly PULSE_W cycles wide.
  - Consecutive pulses are separated by at least GAP low cycles.

## Timing
- Reset values: s_out=0, r_out=0, busy=0, conflict=0, q_model=1 (latch power-up value). Synchronizers, debounced levels, counters and pending flags are 0; state is IDLE.
- Reset mid-pulse aborts the pulse immediately (asynchronous).
- After rst_n releases, an input already held high is treated as a fresh rising edge and is served after the normal latency.
- Latency: if a raw request is stable high from clock edge k, s_out/r_out rises after edge k+DEB_CYCLES+3. This covers 2 synchronizer edges, DEB_CYCLES debounce edges, and 1 FSM edge. With DEB_CYCLES=4, the pulse rises at k+7.
- busy rises in the same cycle as the pulse and falls on the IDLE transition.
- Back-to-back pulses: the next pulse starts on the cycle after the pulse end plus GAP, i.e. one IDLE cycle is always inserted.
- A bounce shorter than DEB_CYCLES cycles produces no pulse.

## Configuration
- SR_CMD_SET_PRIO_EN defined: on conflict, set wins; the FSM goes to SET_P and q_model becomes 1.
- Undefined (default): reset wins as described above.
- conflict behaves the same in both builds.

## Test plan
- Default parameters; hold set_req high from edge 10 → s_out high for edges 17–18; q_model=1; busy high for 3 cycles.
- set_req glitch high for 3 cycles → no pulse; all outputs unchanged.
- set_req and rst_req rise on the same edge → conflict strobe; r_out pulse only; q_model=0. With SR_CMD_SET_PRIO_EN, s_out pulse only and q_model=1.
- rst_req edge arrives while s_out is pulsing → r_out pulse follows after PULSE_W + GAP + 1 cycles with no overlap; s_out and r_out never high together.
- Assert rst_n mid-pulse → s_out=0 and q_model=1 immediately. Release with set_req still high → new s_out pulse DEB_CYCLES+3 edges after release.
- PULSE_W=1, GAP=0; alternate requests → single-cycle pulses; the invariants hold throughout.
